// File: rtl/ysyx_220066_dmem_resp.sv
// Data-memory responder: accepts one load/store at a time, inserts LATENCY
// wait states, accesses a doubleword array and returns extended load data.
module ysyx_220066_dmem_resp #(
    parameter int          DEPTH_LOG2 = 10,
    parameter logic [63:0] BASE       = 64'h0000_0000_8000_0000,
    parameter int          LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    input  logic [2:0]  req_memop,
    output logic        busy,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [63:0] SPAN      = 64'd8 << DEPTH_LOG2;
    localparam logic        ZERO_LAT  = (LATENCY == 0);
    localparam logic [3:0]  LAT_INIT  = 4'(LATENCY);

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic        req;
    logic        do_access;

    // Captured request
    logic [63:0] addr_q, wdata_q;
    logic [7:0]  wmask_q;
    logic [2:0]  memop_q;
    logic        rd_q, wr_q;

    // Operands of the access actually being performed
    logic [63:0] a_addr, a_wdata;
    logic [7:0]  a_wmask;
    logic [2:0]  a_memop;
    logic        a_rd, a_wr;

    logic [63:0] offset;
    logic [DEPTH_LOG2-1:0] idx;
    logic        misalign, bad_op, err;
    logic [63:0] shifted, load_data;

    logic [63:0] mem [DEPTH];

    assign req = req_valid & (req_rd | req_wr);

    // With zero latency the access happens at the accept edge, so the live
    // request is used; otherwise the captured copy drives the access.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        a_addr  = addr_q;
        a_wdata = wdata_q;
        a_wmask = wmask_q;
        a_memop = memop_q;
        a_rd    = rd_q;
        a_wr    = wr_q;
        if (state == IDLE) begin
            a_addr  = req_addr;
            a_wdata = req_wdata;
            a_wmask = req_wmask;
            a_memop = req_memop;
            a_rd    = req_rd;
            a_wr    = req_wr;
        end
    end

    assign do_access = (state == IDLE && req && ZERO_LAT) || (state == WAIT && cnt == 4'd1);

    assign offset = a_addr - BASE;
    assign idx    = offset[DEPTH_LOG2+2:3];

    // Size-based alignment and opcode legality for loads
    always_comb begin
        misalign = 1'b0;
        bad_op   = 1'b0;
        case (a_memop)
            3'd1, 3'd5: misalign = a_addr[0];
            3'd2, 3'd6: misalign = |a_addr[1:0];
            3'd3:       misalign = |a_addr[2:0];
            3'd7:       bad_op   = 1'b1;
            default:    misalign = 1'b0;
        endcase
    end

    assign err = (a_rd & a_wr)
               | (offset >= SPAN)
               | (a_rd & (bad_op | misalign))
               | (a_wr & (a_wmask == 8'h00));

    assign shifted = mem[idx] >> {a_addr[2:0], 3'b000};

    // Truncate and extend the addressed lane per load op
    always_comb begin
        load_data = 64'h0;
        case (a_memop)
            3'd0:    load_data = {{56{shifted[7]}},  shifted[7:0]};
            3'd1:    load_data = {{48{shifted[15]}}, shifted[15:0]};
            3'd2:    load_data = {{32{shifted[31]}}, shifted[31:0]};
            3'd3:    load_data = shifted;
            3'd4:    load_data = {56'h0, shifted[7:0]};
            3'd5:    load_data = {48'h0, shifted[15:0]};
            3'd6:    load_data = {32'h0, shifted[31:0]};
            default: load_data = 64'h0;
        endcase
    end

    // Next-state and stall generation
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE: if (req) begin
                busy       = 1'b1;
                state_next = ZERO_LAT ? RESP : WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt == 4'd1) state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Wait counter: loaded on accept, counts down through WAIT
    always_ff @(posedge clk) begin
        if (!rst)                      cnt <= 4'd0;
        else if (state == IDLE && req) cnt <= LAT_INIT;
        else if (state == WAIT)        cnt <= cnt - 4'd1;
    end

    // Request capture on accept; contents are don't-care until then
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wmask_q <= req_wmask;
            memop_q <= req_memop;
            rd_q    <= req_rd;
            wr_q    <= req_wr;
        end
    end

    // Response registers: strobe for one cycle, data/err hold until next access
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_valid <= 1'b0;
            resp_rdata <= 64'h0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= do_access;
            if (do_access) begin
                resp_err   <= err;
                resp_rdata <= (err || !a_rd) ? 64'h0 : load_data;
            end
        end
    end

    // Byte-masked store into the array; a reset at the access edge cancels it
    always_ff @(posedge clk) begin
        // NOTE: the array is deliberately not reset; contents survive rst.
        if (rst && do_access && a_wr && !err) begin
            for (int i = 0; i < 8; i++) begin
                if (a_wmask[i]) mem[idx][8*i +: 8] <= a_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: doc/ysyx_220066_dmem_resp.md
Name: ysyx_220066_dmem_resp

Overview:
Data-memory responder on the far end of the pipeline's load/store interface. It accepts one read or write request at a time from the memory-access stage: native read/write strobes, 64-bit address, positioned write data and byte mask, and load op. It applies programmable wait states and performs the access on an internal doubleword array. It returns sign/zero-extended load data, and holds the pipeline with a stall signal until the response cycle.

Parameters:
DEPTH_LOG2, 10, log2 of array depth in 64-bit doublewords (default 8 KiB).
BASE, 64'h0000_0000_8000_0000, byte address mapped to array entry 0.
LATENCY, 2, wait-state cycles between accept and response; legal range 0..15.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, synchronous, active-low.
req_valid  in  1  request qualifier from the memory-access stage.
req_rd  in  1  load request.
req_wr  in  1  store request.
req_addr  in  64  byte address.
req_wdata  in  64  store data, already lane-positioned.
req_wmask  in  8  store byte enables, already lane-positioned.
req_memop  in  3  load op (RV funct3): 0 lb, 1 lh, 2 lw, 3 ld, 4 lbu, 5 lhu, 6 lwu; 7 is illegal.
busy  out  1  stall to the pipeline (drives its block input).
resp_valid  out  1  one-cycle response strobe.
resp_rdata  out  64  extended load data; 0 for stores and errors.
resp_err  out  1  access fault; valid with resp_valid.

Behaviour:
- Request taken when req_valid & (req_rd | req_wr); otherwise ignored.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a request, capture addr, wdata, wmask, memop and rd/wr into internal registers.
  - Load the wait counter with LATENCY.
  - Go to WAIT if LATENCY>0, else to RESP.
- WAIT: decrement the counter each cycle. When the counter reaches 1, perform the access at that edge and go to RESP.
- LATENCY=0: the access happens at the accept edge.
- RESP: resp_valid=1 for exactly one cycle, then return to IDLE. Inputs are ignored in RESP.
- busy timing:
  - busy = (state==WAIT) | (state==IDLE & request), combinational, so the stage stalls in the request cycle itself.
  - busy=0 in RESP, which lets the pipeline advance.
  - Response latency is LATENCY+1 cycles from the request cycle.
- Back-to-back requests: a new request is visible in IDLE in the cycle after RESP.
- Error checks, evaluated on captured values. Any failure gives resp_err=1, resp_rdata=0 and no array write.
  - req_rd & req_wr both set.
  - off = addr-BASE; off >= 8<<DEPTH_LOG2, with unsigned wrap, so an address below BASE faults.
  - Read with memop 7.
  - Read misaligned for its size: half needs addr[0]=0, word needs addr[1:0]=0, dword needs addr[2:0]=0.
  - Write with wmask==0.
- Read path:
  - dw = mem[off[DEPTH_LOG2+2:3]], shifted right by addr[2:0]*8.
  - Truncate to 8/16/32/64 bits per memop; sign-extend for ops 0..2, zero-extend for 4..6.
- Write path:
  - For each byte i with wmask[i]=1, mem byte i takes wdata byte i. Other bytes are unchanged.
  - resp_rdata=0, resp_err=0.
- Outputs hold between responses: resp_rdata and resp_err keep their last values, resp_valid=0.
- Reset (rst=0 at an edge):
  - state←IDLE, counter←0, resp_valid←0, resp_err←0, resp_rdata←0, busy=0 from the next cycle.
  - A request in flight is discarded. A write not yet performed is never performed.
  - Array contents are not reset.

Test Plan:
- LATENCY=2, store 64'h1122_3344_5566_7788 to 0x8000_0010, mask 8'hFF → busy high cycles 0–2, resp_valid in cycle 3, err=0. Then ld 0x8000_0010 → 64'h1122334455667788.
- lb 0x8000_0010 with byte 0x88 → FFFF_FFFF_FFFF_FF88. lbu → 0x88. lh 0x8000_0012 → 0x5566. lwu 0x8000_0014 → 0x1122_3344.
- Store mask 8'h0F, wdata 64'hAAAA_AAAA_BBBB_BBBB to 0x8000_0010, then ld → 64'h1122_3344_BBBB_BBBB.
- Errors: lw 0x8000_0002; ld 0x7FFF_FFF8; address 0x8000_2000 at DEPTH_LOG2=10; rd&wr both set. Each → resp_err=1, rdata=0, and a follow-up ld shows memory unchanged.
- LATENCY=0: requests in consecutive available slots → resp_valid 1 cycle after each request, busy only in the request cycles, no lost or duplicated response.
- LATENCY=4, store issued, rst=0 in WAIT cycle 2 → no resp_valid, outputs 0. After reset release, ld at the same address returns the old value.
